// File: rtl/buffer_ctrl.sv
// Pointer/occupancy controller for a parallel Buffer: PAR_WRITE-wide pushes, PAR_READ-wide read window, POP retire.
// Latency: wen/waddr combinational; window advances one cycle after an accepted push or pop.
// Backpressure: wready drops when fewer than PAR_WRITE free slots; rvalid needs PAR_READ occupied. Macro BUFFER_CTRL_ERR_EN enables sticky err.
module buffer_ctrl #(
    parameter int MEM_SIZE    = 4,
    parameter int PAR_WRITE   = 2,
    parameter int PAR_READ    = 3,
    parameter int POP         = 1,
    parameter int ADDRES_SIZE = $clog2(MEM_SIZE),
    parameter int CNT_SIZE    = $clog2(MEM_SIZE + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wvalid,
    output logic                   wready,
    output logic                   wen,
    output logic [ADDRES_SIZE-1:0] waddr,
    input  logic                   rready,
    output logic                   rvalid,
    output logic [ADDRES_SIZE-1:0] raddr,
    output logic [CNT_SIZE-1:0]    count,
    output logic                   full,
    output logic                   empty,
    output logic                   err
);

    localparam logic [CNT_SIZE-1:0]    C_MEM  = CNT_SIZE'(MEM_SIZE);
    localparam logic [CNT_SIZE-1:0]    C_ROOM = CNT_SIZE'(MEM_SIZE - PAR_WRITE);
    localparam logic [CNT_SIZE-1:0]    C_RD   = CNT_SIZE'(PAR_READ);
    localparam logic [CNT_SIZE-1:0]    C_PW   = CNT_SIZE'(PAR_WRITE);
    localparam logic [CNT_SIZE-1:0]    C_POP  = CNT_SIZE'(POP);
    localparam logic [ADDRES_SIZE:0]   P_MEM  = (ADDRES_SIZE+1)'(MEM_SIZE);
    localparam logic [ADDRES_SIZE:0]   P_PW   = (ADDRES_SIZE+1)'(PAR_WRITE);
    localparam logic [ADDRES_SIZE:0]   P_POP  = (ADDRES_SIZE+1)'(POP);

    logic [ADDRES_SIZE-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
    logic [CNT_SIZE-1:0]    cnt, cnt_nxt;
    logic                   push, pop;

    // Modulo add without a divider: the sum stays below 2*MEM_SIZE, so one subtract suffices.
    function automatic logic [ADDRES_SIZE-1:0] wrap_add(input logic [ADDRES_SIZE-1:0] p,
                                                        input logic [ADDRES_SIZE:0]   inc);
        logic [ADDRES_SIZE:0] s;
        s = {1'b0, p} + inc;
        if (s >= P_MEM) s = s - P_MEM;
        return s[ADDRES_SIZE-1:0];
    endfunction

    assign wready = (cnt <= C_ROOM);
    assign rvalid = (cnt >= C_RD);
    assign full   = (cnt == C_MEM);
    assign empty  = (cnt == '0);
    assign push   = wvalid & wready;
    assign pop    = rready & rvalid;
    assign wen    = push;
    assign waddr  = wptr;
    assign raddr  = rptr;
    assign count  = cnt;

    always_comb begin
        wptr_nxt = wptr;
        rptr_nxt = rptr;
        cnt_nxt  = cnt;
        if (push) begin
            wptr_nxt = wrap_add(wptr, P_PW);
            cnt_nxt  = cnt_nxt + C_PW;
        end
        if (pop) begin
            rptr_nxt = wrap_add(rptr, P_POP);
            cnt_nxt  = cnt_nxt - C_POP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            wptr <= wptr_nxt;
            rptr <= rptr_nxt;
            cnt  <= cnt_nxt;
        end
    end

`ifdef BUFFER_CTRL_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else if ((wvalid & ~wready) | (rready & ~rvalid)) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
